// File: rtl/sha256_pkg.sv
// sha256_pkg: shared block geometry, padding constants and padder FSM states.
package sha256_pkg;
    localparam int BLOCK_W         = 512;
    localparam int BLOCK_BYTES     = 64;
    localparam int LEN_FIELD_W     = 64;
    localparam int LEN_OFFSET_BYTE = 56;
    localparam logic [7:0] PAD_BYTE = 8'h80;
    typedef enum logic [2:0] {ABSORB, PAD, ISSUE, GUARD, WAIT} state_t;
endpackage

// File: rtl/sha256_msg_padder_if.sv
// sha256_msg_padder_if: byte stream in, sha256_core handshake/block out, message status.
// master = upstream source plus core side (testbench), slave = the padder.
interface sha256_msg_padder_if;
    import sha256_pkg::*;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_data;
    logic               in_last;
    logic               in_empty;
    logic               core_ready;
    logic               core_init;
    logic               core_next;
    logic               core_mode;
    logic [BLOCK_W-1:0] core_block;
    logic               msg_done;
    logic               busy;
    modport master (
        output in_valid, in_data, in_last, in_empty, core_ready,
        input  in_ready, core_init, core_next, core_mode, core_block, msg_done, busy
    );
    modport slave (
        input  in_valid, in_data, in_last, in_empty, core_ready,
        output in_ready, core_init, core_next, core_mode, core_block, msg_done, busy
    );
endinterface

// File: rtl/sha256_pad_insert.sv
// sha256_pad_insert: combinational padding of a partially filled block.
// Ports: buffer (current block), byte_idx (first free byte), len_bits (message
// length in bits), put_80 (place 0x80 at byte_idx and zero the rest),
// put_len (place len_bits in bytes 56..63) -> block, final_blk.
module sha256_pad_insert
    import sha256_pkg::*;
(
    input  logic [BLOCK_W-1:0]     buffer,
    input  logic [5:0]             byte_idx,
    input  logic [LEN_FIELD_W-1:0] len_bits,
    input  logic                   put_80,
    input  logic                   put_len,
    output logic [BLOCK_W-1:0]     block,
    output logic                   final_blk
);
    always_comb begin
        block = buffer;
        for (int i = 0; i < BLOCK_BYTES; i++)
            if (put_80 && i >= int'(byte_idx))
                block[BLOCK_W-1-8*i -: 8] = (i == int'(byte_idx)) ? PAD_BYTE : 8'h00;
        if (put_len) block[LEN_FIELD_W-1:0] = len_bits;
    end
    assign final_blk = put_len;
endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: assembles a byte stream into FIPS 180-4 padded 512-bit blocks
// and sequences sha256_core init/next/ready.
// Ports: clk, reset_n (async active-low), bus (slave side of sha256_msg_padder_if).
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_BYTES_W = 61,
    parameter bit CORE_MODE   = 1'b1
) (
    input logic                clk,
    input logic                reset_n,
    sha256_msg_padder_if.slave bus
);
    state_t                   state;
    logic [5:0]               byte_idx;
    logic [LEN_BYTES_W-1:0]   len_cnt;
    logic [BLOCK_W-1:0]       buffer;
    logic [BLOCK_W-1:0]       padded;
    logic [LEN_FIELD_W-1:0]   len_bits;
    logic first_blk, pad_pending, len_pending, final_blk;
    logic init_q, next_q, done_q, busy_q;
    logic take, take_byte, put_80, put_len, padded_final;

    assign take      = bus.in_valid && bus.in_ready;
    assign take_byte = take && !bus.in_empty;
    assign len_bits  = LEN_FIELD_W'({len_cnt, 3'b000});
    // A pending length-only block carries no 0x80; otherwise the length fits
    // only when the 0x80 lands before the length field.
    assign put_80    = !len_pending;
    assign put_len   = len_pending || (byte_idx < 6'(LEN_OFFSET_BYTE));

    sha256_pad_insert u_pad (
        .buffer(buffer), .byte_idx(byte_idx), .len_bits(len_bits),
        .put_80(put_80), .put_len(put_len), .block(padded), .final_blk(padded_final)
    );

    assign bus.in_ready   = reset_n && state == ABSORB;
    assign bus.core_block = buffer;
    assign bus.core_mode  = CORE_MODE;
    assign bus.core_init  = init_q;
    assign bus.core_next  = next_q;
    assign bus.msg_done   = done_q;
    assign bus.busy       = busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ABSORB;
            byte_idx    <= '0;
            len_cnt     <= '0;
            buffer      <= '0;
            first_blk   <= 1'b1;
            pad_pending <= 1'b0;
            len_pending <= 1'b0;
            final_blk   <= 1'b0;
            init_q      <= 1'b0;
            next_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            init_q <= 1'b0;
            next_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                ABSORB: if (take) begin
                    busy_q <= 1'b1;
                    if (take_byte) begin
                        buffer[BLOCK_W-1-8*int'(byte_idx) -: 8] <= bus.in_data;
                        byte_idx <= byte_idx + 6'd1;
                        len_cnt  <= len_cnt + LEN_BYTES_W'(1);
                    end
                    // byte_idx wraps to 0 on a full block, ready for the next one
                    if (take_byte && byte_idx == 6'(BLOCK_BYTES-1)) begin
                        state       <= ISSUE;
                        pad_pending <= bus.in_last;
                    end else if (bus.in_last) state <= PAD;
                end
                PAD: begin
                    buffer      <= padded;
                    final_blk   <= padded_final;
                    len_pending <= !padded_final;
                    pad_pending <= 1'b0;
                    state       <= ISSUE;
                end
                ISSUE: if (bus.core_ready) begin
                    init_q    <= first_blk;
                    next_q    <= !first_blk;
                    first_blk <= 1'b0;
                    state     <= GUARD;
                end
                // core_ready may still read high the cycle after the pulse
                GUARD: state <= WAIT;
                WAIT: if (bus.core_ready) begin
                    buffer <= '0;
                    if (final_blk) begin
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        len_cnt     <= '0;
                        byte_idx    <= '0;
                        final_blk   <= 1'b0;
                        pad_pending <= 1'b0;
                        len_pending <= 1'b0;
                        first_blk   <= 1'b1;
                        state       <= ABSORB;
                    end else state <= (pad_pending || len_pending) ? PAD : ABSORB;
                end
                default: state <= ABSORB;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: drives byte messages, models sha256_core, checks blocks and digests.
module tb_sha256_msg_padder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sha256_msg_padder_if bus();
    sha256_msg_padder dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [255:0] H0 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_HELLO = 256'h2cf24dba5fb0a30e26e83b2ac5b9e29e1b161e5c1fa7425e73043362938b9824;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
                 + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return r;
    endfunction

    // sha256_core model: ready drops on a pulse, returns after lat cycles
    logic         core_rdy = 1'b1;
    bit           stall = 1'b0;
    int           lat = 4;
    int           lat_cnt = 0;
    int           n_init = 0, n_next = 0, proto_err = 0, stab_err = 0;
    logic [255:0] hreg = '0;
    logic [511:0] held = '0;
    bit           hold_chk = 1'b0;
    logic [511:0] seen[$];
    assign bus.core_ready = core_rdy && !stall;

    always @(posedge clk) begin
        if (bus.core_init || bus.core_next) begin
            if ((bus.core_init && bus.core_next) || !bus.core_ready) proto_err <= proto_err + 1;
            if (bus.core_init) n_init <= n_init + 1; else n_next <= n_next + 1;
            seen.push_back(bus.core_block);
            held     <= bus.core_block;
            hold_chk <= 1'b1;
            hreg     <= sha_compress(bus.core_init ? H0 : hreg, bus.core_block);
            core_rdy <= 1'b0;
            lat_cnt  <= lat;
        end else if (!core_rdy) begin
            if (!reset_n) hold_chk <= 1'b0;
            else if (hold_chk && bus.core_block !== held) stab_err <= stab_err + 1;
            if (lat_cnt <= 1) begin
                core_rdy <= 1'b1;
                hold_chk <= 1'b0;
            end else lat_cnt <= lat_cnt - 1;
        end
    end

    int vectors = 0;
    int miscompares = 0;
    logic [511:0] exp_blks[$];

    // reference padding: append 0x80, zero to 56 mod 64, then 64-bit bit length
    task automatic ref_pad(input logic [7:0] msg[$]);
        logic [7:0] b[$];
        logic [63:0] bits;
        logic [511:0] x;
        b = msg;
        bits = 64'(msg.size()) * 64'd8;
        b.push_back(8'h80);
        while (b.size() % 64 != 56) b.push_back(8'h00);
        for (int i = 7; i >= 0; i--) b.push_back(bits[8*i +: 8]);
        exp_blks.delete();
        for (int k = 0; k < b.size() / 64; k++) begin
            for (int j = 0; j < 64; j++) x[511-8*j -: 8] = b[64*k+j];
            exp_blks.push_back(x);
        end
    endtask

    task automatic send_msg(input logic [7:0] msg[$], input bit empty_tail, input bit gaps, input bit mark_last);
        int n, beats, t;
        n = msg.size();
        beats = n + (empty_tail ? 1 : 0);
        for (int i = 0; i < beats; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin bus.in_valid = 1'b0; @(negedge clk); end
            bus.in_valid = 1'b1;
            bus.in_data  = (i < n) ? msg[i] : 8'($urandom);
            bus.in_last  = mark_last && i == beats - 1;
            bus.in_empty = i >= n;
            t = 0;
            while (!bus.in_ready && t < 1000) begin @(negedge clk); t++; end
            if (t >= 1000) begin
                vectors++; miscompares++;
                $display("FAIL accept_timeout beat %0d: in_ready %b, want 1", i, bus.in_ready);
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_empty = 1'b0;
    endtask

    task automatic wait_done(output bit done, output bit leak, output bit busy0);
        int t = 0;
        leak = 1'b0;
        busy0 = bus.busy;
        while (!bus.msg_done && t < 3000) begin
            if (bus.in_ready) leak = 1'b1;
            @(negedge clk);
            t++;
        end
        done = bus.msg_done;
    endtask

    task automatic test_message(input string name, input logic [7:0] msg[$], input bit empty_tail, input bit gaps,
                                input int stall_cyc, input bit chk_dig, input logic [255:0] dig);
        int b_seen, b_init, b_next, b_proto, b_stab, nb;
        bit done, leak, busy0;
        ref_pad(msg);
        b_seen = seen.size(); b_init = n_init; b_next = n_next; b_proto = proto_err; b_stab = stab_err;
        stall = stall_cyc > 0;
        send_msg(msg, empty_tail, gaps, 1'b1);
        if (stall_cyc > 0) begin
            repeat (2) @(negedge clk);
            for (int c = 0; c < stall_cyc; c++) begin
                vectors++;
                if (n_init + n_next != b_init + b_next || bus.core_block !== exp_blks[0]) begin
                    miscompares++;
                    $display("FAIL %s stall_hold c%0d: pulses %0d block %h, want 0 pulses block %h",
                             name, c, n_init + n_next - b_init - b_next, bus.core_block, exp_blks[0]);
                end
                @(negedge clk);
            end
            stall = 1'b0;
        end
        wait_done(done, leak, busy0);
        vectors++;
        if (!done) begin miscompares++; $display("FAIL %s msg_done: got timeout, want pulse", name); end
        vectors++;
        if (busy0 !== 1'b1) begin miscompares++; $display("FAIL %s busy_during: got %b want 1", name, busy0); end
        vectors++;
        if (leak) begin miscompares++; $display("FAIL %s in_ready_before_done: got 1 want 0", name); end
        nb = seen.size() - b_seen;
        vectors++;
        if (n_init - b_init != 1) begin
            miscompares++; $display("FAIL %s init_pulses: got %0d want 1", name, n_init - b_init);
        end
        vectors++;
        if (n_next - b_next != exp_blks.size() - 1) begin
            miscompares++; $display("FAIL %s next_pulses: got %0d want %0d", name, n_next - b_next, exp_blks.size() - 1);
        end
        vectors++;
        if (nb != exp_blks.size()) begin
            miscompares++; $display("FAIL %s block_count: got %0d want %0d", name, nb, exp_blks.size());
        end
        for (int k = 0; k < nb && k < exp_blks.size(); k++) begin
            vectors++;
            if (seen[b_seen+k] !== exp_blks[k]) begin
                miscompares++;
                $display("FAIL %s block%0d: got %h want %h", name, k, seen[b_seen+k], exp_blks[k]);
            end
        end
        vectors++;
        if (proto_err != b_proto || stab_err != b_stab) begin
            miscompares++;
            $display("FAIL %s handshake: proto %0d unstable %0d, want 0 0", name, proto_err - b_proto, stab_err - b_stab);
        end
        if (chk_dig) begin
            vectors++;
            if (hreg !== dig) begin miscompares++; $display("FAIL %s digest: got %h want %h", name, hreg, dig); end
        end
        @(negedge clk);
        vectors++;
        if (bus.msg_done !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_done: msg_done %b busy %b, want 0 0", name, bus.msg_done, bus.busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset in_ready: got %b want 0", bus.in_ready); end
        vectors++;
        if ({bus.core_init, bus.core_next, bus.msg_done, bus.busy} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset pulses: init %b next %b done %b busy %b, want 0", bus.core_init, bus.core_next, bus.msg_done, bus.busy);
        end
        vectors++;
        if (bus.core_block !== 512'b0) begin miscompares++; $display("FAIL reset core_block: got %h want 0", bus.core_block); end
        vectors++;
        if (bus.core_mode !== 1'b1) begin miscompares++; $display("FAIL reset core_mode: got %b want 1", bus.core_mode); end
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL idle in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_known_vectors();
        logic [7:0] m[$];
        m = '{8'h61, 8'h62, 8'h63};
        test_message("abc", m, 1'b0, 1'b0, 0, 1'b1, DIG_ABC);
        m.delete();
        test_message("empty", m, 1'b1, 1'b0, 0, 1'b1, DIG_EMPTY);
    endtask

    task automatic test_back_to_back();
        logic [7:0] m[$];
        m = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f};
        test_message("hello", m, 1'b0, 1'b0, 0, 1'b1, DIG_HELLO);
        m = '{8'h61, 8'h62, 8'h63};
        test_message("abc_b2b", m, 1'b0, 1'b0, 0, 1'b1, DIG_ABC);
    endtask

    task automatic test_boundaries();
        logic [7:0] m[$];
        m.delete(); repeat (56) m.push_back(8'h61);
        test_message("56x61", m, 1'b0, 1'b0, 0, 1'b0, '0);
        m.delete(); repeat (64) m.push_back(8'h00);
        test_message("64x00", m, 1'b0, 1'b0, 0, 1'b0, '0);
        test_message("64x00_empty_tail", m, 1'b1, 1'b0, 0, 1'b0, '0);
        m.delete(); repeat (55) m.push_back(8'($urandom));
        test_message("len55", m, 1'b0, 1'b1, 0, 1'b0, '0);
        m.delete(); repeat (63) m.push_back(8'($urandom));
        test_message("len63_empty_tail", m, 1'b1, 1'b1, 0, 1'b0, '0);
    endtask

    task automatic test_stall();
        logic [7:0] m[$];
        m = '{8'h61, 8'h62, 8'h63};
        test_message("abc_stall", m, 1'b0, 1'b0, 10, 1'b1, DIG_ABC);
    endtask

    task automatic test_reset_mid();
        logic [7:0] m[$];
        int p0, t;
        m.delete(); repeat (20) m.push_back(8'($urandom));
        send_msg(m, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.core_block !== 512'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_block: busy %b in_ready %b block %h, want all 0", bus.busy, bus.in_ready, bus.core_block);
        end
        @(negedge clk); reset_n = 1'b1; @(negedge clk);
        lat = 20;
        p0 = n_init + n_next;
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0, 1'b0, 1'b1);
        t = 0;
        while (n_init + n_next == p0 && t < 100) begin @(negedge clk); t++; end
        vectors++;
        if (t >= 100) begin miscompares++; $display("FAIL reset_wait pulse: got timeout, want pulse"); end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.core_block !== 512'b0 || bus.busy !== 1'b0 || bus.core_init !== 1'b0 || bus.core_next !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_wait: busy %b init %b next %b block %h, want all 0",
                     bus.busy, bus.core_init, bus.core_next, bus.core_block);
        end
        p0 = n_init + n_next;
        @(negedge clk); reset_n = 1'b1;
        repeat (30) @(negedge clk);
        vectors++;
        if (n_init + n_next != p0) begin
            miscompares++; $display("FAIL reset_no_pulses: got %0d pulses want 0", n_init + n_next - p0);
        end
        lat = 4;
        test_message("abc_after_reset", m, 1'b0, 1'b0, 0, 1'b1, DIG_ABC);
    endtask

    task automatic test_random();
        logic [7:0] m[$];
        int len;
        for (int r = 0; r < 12; r++) begin
            len = $urandom_range(0, 150);
            m.delete();
            repeat (len) m.push_back(8'($urandom));
            lat = $urandom_range(1, 6);
            test_message($sformatf("rand%0d_len%0d", r, len), m, len == 0 || $urandom_range(0, 1) == 1,
                         1'b1, 0, 1'b0, '0);
        end
        lat = 4;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0; bus.in_empty = 1'b0;
        test_reset();
        test_known_vectors();
        test_back_to_back();
        test_boundaries();
        test_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
